// File: rtl/sample_frame_sequencer.sv
// Capture-and-stream sequencer: latches the 64-bit translator bus on a hardware or
// software trigger and emits a framed packet (header, mask, selected lanes, XOR sum).
module sample_frame_sequencer #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter logic [7:0] CMD_TRIG = 8'h53,
  parameter logic [7:0] CMD_MASK = 8'h4D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_in,
  input  logic        trig_in,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  output logic [7:0]  enable_bit,
  output logic        busy,
  output logic [7:0]  overrun_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_MSK, S_LANE, S_CSUM, S_GAP
  } state_t;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic        trig_last_q;
  logic        mask_pending_q, mask_pending_d;
  logic [7:0]  lane_mask_q, lane_mask_d;
  logic [63:0] cap_q, cap_d;
  logic [7:0]  frame_mask_q, frame_mask_d;
  logic [7:0]  csum_q, csum_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  ovr_q, ovr_d;

  logic        trig_evt;
  logic [2:0]  sel;
  logic        sel_found;
  logic        more_after;
  logic [7:0]  lane_byte;

  assign trig_evt = (trig_in && !trig_last_q) ||
                    (new_rx_data && !mask_pending_q && (rx_data == CMD_TRIG));

  assign enable_bit    = lane_mask_q;
  assign busy          = (state_q != S_IDLE);
  assign overrun_count = ovr_q;

  // Lowest set mask bit at or above idx, and whether any set bit lies beyond it,
  // so the last lane hands straight to the checksum without an extra cycle.
  always_comb begin
    sel        = '0;
    sel_found  = 1'b0;
    more_after = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (frame_mask_q[i] && (3'(i) >= idx_q) && !sel_found) begin
        sel       = 3'(i);
        sel_found = 1'b1;
      end else if (frame_mask_q[i] && sel_found) begin
        more_after = 1'b1;
      end
    end
  end

  assign lane_byte = cap_q[{sel, 3'b000} +: 8];

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    mask_pending_d = mask_pending_q;
    lane_mask_d    = lane_mask_q;
    cap_d          = cap_q;
    frame_mask_d   = frame_mask_q;
    csum_d         = csum_q;
    idx_d          = idx_q;
    ovr_d          = ovr_q;
    tx_data        = '0;
    new_tx_data    = 1'b0;

    if (new_rx_data) begin
      if (mask_pending_q) begin
        lane_mask_d    = rx_data;
        mask_pending_d = 1'b0;
      end else if (rx_data == CMD_MASK) begin
        mask_pending_d = 1'b1;
      end
    end

    if (trig_evt && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig_evt) begin
          cap_d        = data_in;
          frame_mask_d = lane_mask_q;
          csum_d       = '0;
          idx_d        = '0;
          state_d      = S_HDR;
        end
      end
      S_HDR: begin
        tx_data = HEADER;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          csum_d      = csum_q ^ HEADER;
          ret_d       = S_MSK;
          state_d     = S_GAP;
        end
      end
      S_MSK: begin
        tx_data = frame_mask_q;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          csum_d      = csum_q ^ frame_mask_q;
          ret_d       = (frame_mask_q != '0) ? S_LANE : S_CSUM;
          state_d     = S_GAP;
        end
      end
      S_LANE: begin
        if (!sel_found) begin
          state_d = S_CSUM;
        end else begin
          tx_data = lane_byte;
          if (!tx_busy) begin
            new_tx_data = 1'b1;
            csum_d      = csum_q ^ lane_byte;
            idx_d       = sel + 3'd1;
            ret_d       = more_after ? S_LANE : S_CSUM;
            state_d     = S_GAP;
          end
        end
      end
      S_CSUM: begin
        tx_data = csum_q;
        if (!tx_busy) begin
          new_tx_data = 1'b1;
          ret_d       = S_IDLE;
          state_d     = S_GAP;
        end
      end
      S_GAP:   state_d = ret_q;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ret_q          <= S_IDLE;
      trig_last_q    <= 1'b1;
      mask_pending_q <= 1'b0;
      lane_mask_q    <= 8'hFF;
      cap_q          <= '0;
      frame_mask_q   <= '0;
      csum_q         <= '0;
      idx_q          <= '0;
      ovr_q          <= '0;
    end else begin
      state_q        <= state_d;
      ret_q          <= ret_d;
      trig_last_q    <= trig_in;
      mask_pending_q <= mask_pending_d;
      lane_mask_q    <= lane_mask_d;
      cap_q          <= cap_d;
      frame_mask_q   <= frame_mask_d;
      csum_q         <= csum_d;
      idx_q          <= idx_d;
      ovr_q          <= ovr_d;
    end
  end

endmodule
